// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit and the control unit that consumes its opcode.
// Word, opcode and PC sizes, the opcode bit positions and the fetch state encodings.
package fetch_unit_pkg;

   localparam int opcode_size = 5;
   localparam int instr_size  = 16;
   localparam int pc_size     = 8;

   // Opcode field shared with the control unit's decode ROM
   localparam int opcode_msb  = instr_size - 1;
   localparam int opcode_lsb  = instr_size - opcode_size;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT     = 2'd1,
      ST_REDIRECT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_prefetch_buf.sv
// One-entry prefetch buffer: one instruction word plus the address it was fetched from.
// Only present when FETCH_PREFETCH_EN is defined; flush wins over fill, fill wins over take.
`ifdef FETCH_PREFETCH_EN
module fetch_unit_prefetch_buf #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fill,
   input  logic [DATA_W-1:0] fill_data,
   input  logic [ADDR_W-1:0] fill_addr,
   input  logic              take,
   input  logic              flush,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [ADDR_W-1:0] addr
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         addr  <= '0;
      end else begin
         if (flush) begin
            valid <= 1'b0;
         end else if (fill) begin
            valid <= 1'b1;
         end else if (take) begin
            valid <= 1'b0;
         end
         if (fill && !flush) begin
            data <= fill_data;
            addr <= fill_addr;
         end
      end
   end

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches words over imem req/ack, presents the opcode.
// Optional one-entry prefetch is enabled by defining FETCH_PREFETCH_EN.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W  = pc_size,
   parameter int INSTR_W = instr_size
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fetch_req,
   input  logic                   pc_load,
   input  logic [ADDR_W-1:0]      pc_load_val,
   output logic                   imem_req,
   output logic [ADDR_W-1:0]      imem_addr,
   input  logic                   imem_ack,
   input  logic [INSTR_W-1:0]     imem_data,
   output logic [INSTR_W-1:0]     ir,
   output logic [opcode_size-1:0] opcode,
   output logic [ADDR_W-1:0]      pc,
   output logic                   ir_valid,
   output logic                   busy,
   output fetch_state_e           dbg_state
);

   // Handshake: imem_req rises together with imem_addr and both hold steady until the
   // cycle imem_ack is sampled high; req then drops. An ack with no request outstanding
   // (IDLE, REDIRECT, or after reset) is ignored.

   fetch_state_e       state_q, state_n;
   logic [ADDR_W-1:0]  pc_q, pc_n, pc_eff;
   logic [INSTR_W-1:0] ir_q, ir_n;
   logic               req_q, req_n;
   logic [ADDR_W-1:0]  addr_q, addr_n;
   logic               irv_q, irv_n;
   logic               pend_q, pend_n;
   logic [ADDR_W-1:0]  tgt_q, tgt_n;

`ifdef FETCH_PREFETCH_EN
   // demand: the control unit is waiting on the outstanding fetch.
   // armed: prefetching starts only once the IR has been loaded at least once.
   logic               demand_q, demand_n;
   logic               armed_q, armed_n;
   logic               buf_fill, buf_take, buf_flush;
   logic               buf_valid, buf_hit;
   logic [INSTR_W-1:0] buf_data;
   logic [ADDR_W-1:0]  buf_addr;

   fetch_unit_prefetch_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (INSTR_W)
   ) prefetch_buf (
      .clk       (clk),
      .rst       (rst),
      .fill      (buf_fill),
      .fill_data (imem_data),
      .fill_addr (addr_q),
      .take      (buf_take),
      .flush     (buf_flush),
      .valid     (buf_valid),
      .data      (buf_data),
      .addr      (buf_addr)
   );

   assign buf_hit = buf_valid && (buf_addr == pc_q);
`endif

   assign pc_eff = pc_load ? pc_load_val : pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= '0;
         ir_q     <= '0;
         req_q    <= 1'b0;
         addr_q   <= '0;
         irv_q    <= 1'b0;
         pend_q   <= 1'b0;
         tgt_q    <= '0;
`ifdef FETCH_PREFETCH_EN
         demand_q <= 1'b0;
         armed_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_n;
         pc_q     <= pc_n;
         ir_q     <= ir_n;
         req_q    <= req_n;
         addr_q   <= addr_n;
         irv_q    <= irv_n;
         pend_q   <= pend_n;
         tgt_q    <= tgt_n;
`ifdef FETCH_PREFETCH_EN
         demand_q <= demand_n;
         armed_q  <= armed_n;
`endif
      end
   end

   always_comb begin
      state_n   = state_q;
      pc_n      = pc_q;
      ir_n      = ir_q;
      req_n     = req_q;
      addr_n    = addr_q;
      irv_n     = 1'b0;
      pend_n    = pend_q;
      tgt_n     = tgt_q;
`ifdef FETCH_PREFETCH_EN
      demand_n  = demand_q;
      armed_n   = armed_q;
      buf_fill  = 1'b0;
      buf_take  = 1'b0;
      buf_flush = pc_load;
`endif
      unique case (state_q)
         ST_IDLE: begin
            // A jump in the same cycle as a request is fetched from the new target
            pc_n = pc_eff;
`ifdef FETCH_PREFETCH_EN
            if (fetch_req && buf_hit && !pc_load) begin
               ir_n     = buf_data;
               pc_n     = pc_q + ADDR_W'(1);
               irv_n    = 1'b1;
               buf_take = 1'b1;
               armed_n  = 1'b1;
               req_n    = 1'b1;
               addr_n   = pc_q + ADDR_W'(1);
               demand_n = 1'b0;
               state_n  = ST_WAIT;
            end else if (fetch_req || (armed_q && (!buf_valid || pc_load))) begin
               req_n    = 1'b1;
               addr_n   = pc_eff;
               demand_n = fetch_req;
               state_n  = ST_WAIT;
            end
`else
            if (fetch_req) begin
               req_n   = 1'b1;
               addr_n  = pc_eff;
               state_n = ST_WAIT;
            end
`endif
         end

         ST_WAIT: begin
            if (pc_load) begin
               pend_n = 1'b1;
               tgt_n  = pc_load_val;
            end
`ifdef FETCH_PREFETCH_EN
            if (fetch_req) begin
               demand_n = 1'b1;
            end
`endif
            if (imem_ack) begin
               req_n   = 1'b0;
               state_n = ST_IDLE;
               if (pc_load || pend_q) begin
                  // Word belongs to the abandoned path: drop it and refetch the target
                  pc_n    = pc_load ? pc_load_val : tgt_q;
                  pend_n  = 1'b0;
                  state_n = ST_REDIRECT;
`ifdef FETCH_PREFETCH_EN
               end else if (!demand_n) begin
                  buf_fill = 1'b1;
`endif
               end else begin
                  ir_n  = imem_data;
                  pc_n  = pc_q + ADDR_W'(1);
                  irv_n = 1'b1;
`ifdef FETCH_PREFETCH_EN
                  demand_n = 1'b0;
                  armed_n  = 1'b1;
`endif
               end
            end
         end

         ST_REDIRECT: begin
            pc_n    = pc_eff;
            req_n   = 1'b1;
            addr_n  = pc_eff;
            state_n = ST_WAIT;
`ifdef FETCH_PREFETCH_EN
            if (fetch_req) begin
               demand_n = 1'b1;
            end
`endif
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign ir        = ir_q;
   assign opcode    = ir_q[INSTR_W-1 -: opcode_size];
   assign pc        = pc_q;
   assign ir_valid  = irv_q;
   assign dbg_state = state_q;
`ifdef FETCH_PREFETCH_EN
   assign busy      = demand_q;
`else
   assign busy      = (state_q != ST_IDLE);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory responder plus hand-computed
// expectations for reset, zero/multi-wait fetches, PC wrap, jump redirects and reset abort.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic        pc_load;
   logic [7:0]  pc_load_val;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic [15:0] ir;
   logic [4:0]  opcode;
   logic [7:0]  pc;
   logic        ir_valid;
   logic        busy;
   fetch_state_e dbg_state;

   logic [15:0] mem [256];
   logic        mem_en;
   logic        mem_ack;
   logic        man_ack;
   logic [15:0] man_data;
   int          mem_lat;
   int          mem_cnt;

   int          n_tests = 0;
   int          n_fail = 0;
   int          valid_cnt = 0;
   logic [7:0]  watch_addr;
   logic        watch_hit;

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req),
      .pc_load     (pc_load),
      .pc_load_val (pc_load_val),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .ir          (ir),
      .opcode      (opcode),
      .pc          (pc),
      .ir_valid    (ir_valid),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- memory responder ----------------
   assign imem_ack  = mem_ack | man_ack;
   assign imem_data = man_ack ? man_data : mem[imem_addr];

   // Acks a request after mem_lat idle cycles; ack lasts one cycle
   always @(negedge clk) begin
      if (!mem_en || mem_ack) begin
         mem_ack = 1'b0;
         mem_cnt = 0;
      end else if (imem_req) begin
         if (mem_cnt >= mem_lat) begin
            mem_ack = 1'b1;
            mem_cnt = 0;
         end else begin
            mem_cnt++;
         end
      end else begin
         mem_cnt = 0;
      end
   end

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (ir_valid) valid_cnt++;
      if (imem_req && imem_addr == watch_addr) watch_hit = 1'b1;
   endtask

   task automatic pulse_fetch();
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
   endtask

   task automatic load_pc(input logic [7:0] v);
      pc_load     = 1'b1;
      pc_load_val = v;
      tick();
      pc_load     = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int max_cyc);
      int n = 0;
      while (!ir_valid && n < max_cyc) begin
         tick();
         n++;
      end
      check_eq(tag, 32'(ir_valid), 32'(1'b1));
   endtask

   task automatic run_redirect(input int lat, input logic [7:0] start, input logic [7:0] target,
                               input logic [15:0] exp_word, input logic [4:0] exp_op);
      int v0;
      mem_lat = lat;
      load_pc(start);
      pulse_fetch();
      check_eq("redir_addr0", 32'(imem_addr), 32'(start));
      v0 = valid_cnt;
      watch_addr = target;
      watch_hit  = 1'b0;
      load_pc(target);
      wait_valid("redir_valid", 20);
      check_eq("redir_reissue", 32'(watch_hit), 32'(1'b1));
      check_eq("redir_ir", 32'(ir), 32'(exp_word));
      check_eq("redir_opcode", 32'(opcode), 32'(exp_op));
      check_eq("redir_pc", 32'(pc), 32'(8'(target + 8'd1)));
      repeat (3) tick();
      check_eq("redir_pulses", 32'(valid_cnt - v0), 32'(1));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int v0;
      rst = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_load_val = '0;
      man_ack = 1'b0; man_data = '0; mem_ack = 1'b0; mem_cnt = 0;
      mem_en = 1'b1; mem_lat = 0; watch_addr = '0; watch_hit = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'h5A00;
      mem[8'h00] = 16'h3A05;
      mem[8'h01] = 16'hA1B2;
      mem[8'h05] = 16'hDEAD;
      mem[8'h10] = 16'hBAD0;
      mem[8'h20] = 16'h7E01;
      mem[8'h40] = 16'h4321;
      mem[8'h60] = 16'hF00F;
      mem[8'hFF] = 16'h1234;

      repeat (2) tick();
      rst = 1'b0;
      check_eq("rst_pc", 32'(pc), 32'(0));
      check_eq("rst_ir", 32'(ir), 32'(0));
      check_eq("rst_opcode", 32'(opcode), 32'(0));
      check_eq("rst_req", 32'(imem_req), 32'(0));
      check_eq("rst_addr", 32'(imem_addr), 32'(0));
      check_eq("rst_valid", 32'(ir_valid), 32'(0));
      check_eq("rst_busy", 32'(busy), 32'(0));
      check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));

`ifdef FETCH_PREFETCH_EN
      // first fetch is a demand miss, then the buffer fills from pc=1
      pulse_fetch();
      check_eq("pf_first_valid_t1", 32'(ir_valid), 32'(0));
      tick();
      check_eq("pf_first_valid", 32'(ir_valid), 32'(1));
      check_eq("pf_first_ir", 32'(ir), 32'(16'h3A05));
      repeat (4) tick();
      pulse_fetch();
      check_eq("pf_hit_valid", 32'(ir_valid), 32'(1));
      check_eq("pf_hit_ir", 32'(ir), 32'(16'hA1B2));
      check_eq("pf_hit_pc", 32'(pc), 32'(2));
      repeat (4) tick();
      mem_lat = 2;
      load_pc(8'h40);
      pulse_fetch();
      check_eq("pf_miss_valid", 32'(ir_valid), 32'(0));
      check_eq("pf_miss_busy", 32'(busy), 32'(1));
      wait_valid("pf_miss_done", 20);
      check_eq("pf_miss_ir", 32'(ir), 32'(16'h4321));
      check_eq("pf_miss_pc", 32'(pc), 32'(8'h41));
`else
      // zero-wait fetch from address 0
      pulse_fetch();
      check_eq("zw_req", 32'(imem_req), 32'(1));
      check_eq("zw_addr", 32'(imem_addr), 32'(0));
      check_eq("zw_busy", 32'(busy), 32'(1));
      check_eq("zw_state", 32'(dbg_state), 32'(ST_WAIT));
      check_eq("zw_valid_early", 32'(ir_valid), 32'(0));
      tick();
      check_eq("zw_valid", 32'(ir_valid), 32'(1));
      check_eq("zw_ir", 32'(ir), 32'(16'h3A05));
      check_eq("zw_opcode", 32'(opcode), 32'(5'b00111));
      check_eq("zw_pc", 32'(pc), 32'(1));
      check_eq("zw_req_drop", 32'(imem_req), 32'(0));
      tick();
      check_eq("zw_valid_pulse", 32'(ir_valid), 32'(0));

      // three wait cycles, a fetch_req pulse while busy is ignored
      mem_lat = 3;
      v0 = valid_cnt;
      pulse_fetch();
      for (int i = 0; i < 4; i++) begin
         check_eq("ws_req_hold", 32'(imem_req), 32'(1));
         check_eq("ws_addr_hold", 32'(imem_addr), 32'(1));
         if (i == 1) pulse_fetch();
         else tick();
      end
      check_eq("ws_valid", 32'(ir_valid), 32'(1));
      check_eq("ws_ir", 32'(ir), 32'(16'hA1B2));
      check_eq("ws_pc", 32'(pc), 32'(2));
      repeat (3) tick();
      check_eq("ws_no_queue_req", 32'(imem_req), 32'(0));
      check_eq("ws_no_queue_busy", 32'(busy), 32'(0));
      check_eq("ws_pulses", 32'(valid_cnt - v0), 32'(1));

      // jump and fetch in the same idle cycle uses the new target
      mem_lat = 0;
      fetch_req = 1'b1; pc_load = 1'b1; pc_load_val = 8'h20;
      tick();
      fetch_req = 1'b0; pc_load = 1'b0;
      check_eq("ldf_addr", 32'(imem_addr), 32'(8'h20));
      wait_valid("ldf_valid", 10);
      check_eq("ldf_ir", 32'(ir), 32'(16'h7E01));
      check_eq("ldf_pc", 32'(pc), 32'(8'h21));
      tick();

      // PC wrap from all-ones
      load_pc(8'hFF);
      check_eq("wrap_pc_load", 32'(pc), 32'(8'hFF));
      pulse_fetch();
      check_eq("wrap_addr", 32'(imem_addr), 32'(8'hFF));
      wait_valid("wrap_valid", 10);
      check_eq("wrap_pc", 32'(pc), 32'(8'h00));
      check_eq("wrap_ir", 32'(ir), 32'(16'h1234));
      check_eq("wrap_opcode", 32'(opcode), 32'(5'b00010));
      tick();

      // jump while waiting (pending), then jump coinciding with the ack
      run_redirect(2, 8'h05, 8'h40, 16'h4321, 5'b01000);
      run_redirect(0, 8'h10, 8'h60, 16'hF00F, 5'b11110);

      // reset during WAIT, then a stray ack
      mem_en = 1'b0;
      pulse_fetch();
      tick();
      check_eq("ra_pre_busy", 32'(busy), 32'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      man_ack = 1'b1; man_data = 16'hBEEF;
      tick();
      man_ack = 1'b0;
      check_eq("ra_ack_valid", 32'(ir_valid), 32'(0));
      check_eq("ra_ack_ir", 32'(ir), 32'(0));
      tick();
      check_eq("ra_ir", 32'(ir), 32'(0));
      check_eq("ra_opcode", 32'(opcode), 32'(0));
      check_eq("ra_pc", 32'(pc), 32'(0));
      check_eq("ra_req", 32'(imem_req), 32'(0));
      check_eq("ra_addr", 32'(imem_addr), 32'(0));
      check_eq("ra_busy", 32'(busy), 32'(0));
      check_eq("ra_valid", 32'(ir_valid), 32'(0));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
